// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: aligns/extends load data, stalls upstream while dmem is not ready.
// Optional MEM_WB_LWLR_EN enables LWL/LWR merging; without it those loads raise bus_err.
module mem_wb_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exmem_valid,
  input  logic                  exmem_reg_write,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_addr,
  input  logic [DATA_WIDTH-1:0] exmem_alu_result,
  input  logic [2:0]            exmem_load_type,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] memwb_data,
  output logic [ADDR_WIDTH-1:0] memwb_rd_addr,
  output logic [3:0]            memwb_byte_en,
  output logic                  stall_out,
  output logic                  bus_err
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);

  logic [0:0]            state;
  logic [7:0]            wait_cnt;
  logic                  live;
  logic                  is_load;
  logic                  timeout;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [3:0]            ld_be;
  logic                  ld_bad;

  assign live       = exmem_valid & exmem_reg_write & (exmem_rd_addr != '0);
  assign is_load    = exmem_load_type != 3'd0;
  assign off        = exmem_alu_result[1:0];
  assign byte_shift = dmem_rdata >> {off, 3'b000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign timeout    = (state == S_WAIT) && (wait_cnt == TMO);

  // Load formatting; misaligned or unsupported load types flag ld_bad.
  always_comb begin
    ld_data = '0;
    ld_be   = 4'b1111;
    ld_bad  = 1'b0;
    case (exmem_load_type)
      3'd0: ld_data = exmem_alu_result;
      3'd1: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd2: ld_data = {24'd0, ld_byte};
      3'd3: begin
        if (off[0]) ld_bad = 1'b1;
        else        ld_data = {{16{ld_half[15]}}, ld_half};
      end
      3'd4: begin
        if (off[0]) ld_bad = 1'b1;
        else        ld_data = {16'd0, ld_half};
      end
      3'd5: begin
        if (off != 2'd0) ld_bad = 1'b1;
        else             ld_data = dmem_rdata;
      end
`ifdef MEM_WB_LWLR_EN
      3'd6: begin
        ld_data = dmem_rdata << {2'd3 - off, 3'b000};
        ld_be   = 4'b1111 << (2'd3 - off);
      end
      3'd7: begin
        ld_data = byte_shift;
        ld_be   = 4'b1111 >> off;
      end
`endif
      default: ld_bad = 1'b1;
    endcase
    if (ld_bad) ld_be = 4'b0000;
  end

  // The capture cycle out of WAIT and the timeout cycle both release upstream.
  assign stall_out = ~flush &
                     (((state == S_RUN) & live & is_load & ~ld_bad & ~dmem_ready) |
                      ((state == S_WAIT) & ~timeout & ~dmem_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RUN;
      wait_cnt      <= '0;
      memwb_data    <= '0;
      memwb_rd_addr <= '0;
      memwb_byte_en <= 4'b0000;
      bus_err       <= 1'b0;
    end else begin
      memwb_data    <= '0;
      memwb_rd_addr <= '0;
      memwb_byte_en <= 4'b0000;
      bus_err       <= 1'b0;
      if (flush) begin
        state    <= S_RUN;
        wait_cnt <= '0;
      end else if (state == S_RUN) begin
        if (live) begin
          if (ld_bad) begin
            bus_err <= 1'b1;
          end else if (is_load && !dmem_ready) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd1;
          end else begin
            memwb_data    <= ld_data;
            memwb_rd_addr <= exmem_rd_addr;
            memwb_byte_en <= ld_be;
          end
        end
      end else begin
        if (timeout) begin
          bus_err  <= 1'b1;
          state    <= S_RUN;
          wait_cnt <= '0;
        end else if (dmem_ready) begin
          memwb_data    <= ld_data;
          memwb_rd_addr <= exmem_rd_addr;
          memwb_byte_en <= ld_be;
          state         <= S_RUN;
          wait_cnt      <= '0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: cycle-by-cycle reference model compare plus directed literal checks.
// Honours MEM_WB_LWLR_EN the same way as the design.
module tb_mem_wb_stage;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        rw = 1'b0;
  logic [4:0]  rd_a = 5'd0;
  logic [31:0] alu = 32'd0;
  logic [2:0]  lt = 3'd0;
  logic [31:0] rdata = 32'd0;
  logic        ready = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] memwb_data;
  logic [4:0]  memwb_rd_addr;
  logic [3:0]  memwb_byte_en;
  logic        stall_out;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  mem_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .exmem_valid(valid), .exmem_reg_write(rw), .exmem_rd_addr(rd_a),
    .exmem_alu_result(alu), .exmem_load_type(lt),
    .dmem_rdata(rdata), .dmem_ready(ready), .flush(flush),
    .memwb_data(memwb_data), .memwb_rd_addr(memwb_rd_addr),
    .memwb_byte_en(memwb_byte_en), .stall_out(stall_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load formatting from the load-type table, in plain arithmetic.
  function automatic void ref_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] r,
                                   output logic [31:0] d, output logic [3:0] be, output logic isbad);
    int off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(a[1:0]);
    b = (r >> (8 * off)) & 32'hFF;
    h = (r >> (16 * (off / 2))) & 32'hFFFF;
    d = 32'd0;
    be = 4'hF;
    isbad = 1'b0;
    case (t)
      3'd0: d = a;
      3'd1: d = {{24{b[7]}}, b[7:0]};
      3'd2: d = b;
      3'd3: if (off % 2 == 1) isbad = 1'b1; else d = {{16{h[15]}}, h[15:0]};
      3'd4: if (off % 2 == 1) isbad = 1'b1; else d = h;
      3'd5: if (off != 0) isbad = 1'b1; else d = r;
`ifdef MEM_WB_LWLR_EN
      3'd6: begin d = r << (8 * (3 - off)); be = 4'(4'hF << (3 - off)); end
      3'd7: begin d = r >> (8 * off); be = 4'(4'hF >> off); end
`endif
      default: isbad = 1'b1;
    endcase
    if (isbad) be = 4'h0;
  endfunction

  // Model state: whether a load is outstanding and how many cycles it has stalled.
  logic        m_wait = 1'b0;
  int          m_cnt = 0;
  logic [31:0] e_d = 32'd0;
  logic [4:0]  e_rd = 5'd0;
  logic [3:0]  e_be = 4'd0;
  logic        e_err = 1'b0;

  logic        n_wait;
  int          n_cnt;
  logic [31:0] n_d;
  logic [4:0]  n_rd;
  logic [3:0]  n_be;
  logic        n_err;
  logic        e_stall;
  logic [31:0] l_d;
  logic [3:0]  l_be;
  logic        l_bad;
  logic        m_live;

  always_comb begin
    n_wait = m_wait;
    n_cnt = m_cnt;
    n_d = 32'd0;
    n_rd = 5'd0;
    n_be = 4'd0;
    n_err = 1'b0;
    e_stall = 1'b0;
    ref_load(lt, alu, rdata, l_d, l_be, l_bad);
    m_live = valid && rw && (rd_a != 5'd0);
    if (flush) begin
      n_wait = 1'b0;
      n_cnt = 0;
    end else if (!m_wait) begin
      if (m_live) begin
        if (l_bad) n_err = 1'b1;
        else if (lt != 3'd0 && !ready) begin
          n_wait = 1'b1;
          n_cnt = 1;
          e_stall = 1'b1;
        end else begin
          n_d = l_d; n_be = l_be; n_rd = rd_a;
        end
      end
    end else if (m_cnt == TMO) begin
      n_err = 1'b1;
      n_wait = 1'b0;
      n_cnt = 0;
    end else if (ready) begin
      n_d = l_d; n_be = l_be; n_rd = rd_a;
      n_wait = 1'b0;
      n_cnt = 0;
    end else begin
      n_cnt = m_cnt + 1;
      e_stall = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 1'b0; m_cnt <= 0;
      e_d <= 32'd0; e_rd <= 5'd0; e_be <= 4'd0; e_err <= 1'b0;
    end else begin
      m_wait <= n_wait; m_cnt <= n_cnt;
      e_d <= n_d; e_rd <= n_rd; e_be <= n_be; e_err <= n_err;
    end
  end

  always @(negedge clk) begin
    chk("m_byte_en", 32'(memwb_byte_en), 32'(e_be));
    chk("m_bus_err", 32'(bus_err), 32'(e_err));
    chk("m_stall", 32'(stall_out), 32'(e_stall));
    if (e_be != 4'd0) begin
      chk("m_data", memwb_data, e_d);
      chk("m_rd", 32'(memwb_rd_addr), 32'(e_rd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic w, input logic [4:0] r, input logic [31:0] a,
                        input logic [2:0] t, input logic [31:0] rdt, input logic rdy);
    valid = v; rw = w; rd_a = r; alu = a; lt = t; rdata = rdt; ready = rdy;
  endtask

  task automatic nop();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 1'b0);
  endtask

  int n;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_data", memwb_data, 32'd0);
    chk("rst_rd", 32'(memwb_rd_addr), 32'd0);
    chk("rst_be", 32'(memwb_byte_en), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    rst_n = 1'b1;
    cyc();

    // ALU pass-through
    set_in(1, 1, 5'd5, 32'h1234_5678, 3'd0, 32'd0, 1'b0);
    cyc(); nop();
    chk("alu_data", memwb_data, 32'h1234_5678);
    chk("alu_rd", 32'(memwb_rd_addr), 32'd5);
    chk("alu_be", 32'(memwb_byte_en), 32'hF);

    // Byte and halfword loads
    set_in(1, 1, 5'd3, 32'h0000_1003, 3'd1, 32'h80AA_BBCC, 1'b1);
    cyc();
    chk("lb_data", memwb_data, 32'hFFFF_FF80);
    chk("lb_be", 32'(memwb_byte_en), 32'hF);
    lt = 3'd2;
    cyc();
    chk("lbu_data", memwb_data, 32'h0000_0080);
    set_in(1, 1, 5'd4, 32'h0000_2002, 3'd3, 32'h80AA_BBCC, 1'b1);
    cyc();
    chk("lh_data", memwb_data, 32'hFFFF_80AA);
    set_in(1, 1, 5'd4, 32'h0000_2000, 3'd4, 32'h80AA_BBCC, 1'b1);
    cyc();
    chk("lhu_data", memwb_data, 32'h0000_BBCC);
    // Non-writing instruction is a bubble
    set_in(1, 0, 5'd9, 32'h0, 3'd0, 32'h0, 1'b1);
    cyc(); nop();
    chk("norw_be", 32'(memwb_byte_en), 32'd0);

    // LW with ready low for 3 cycles
    set_in(1, 1, 5'd7, 32'h0000_0100, 3'd5, 32'hDEAD_BEEF, 1'b0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_out) n++;
      cyc();
    end
    ready = 1'b1;
    #1;
    chk("lw_stall_drop", 32'(stall_out), 32'd0);
    cyc(); nop();
    chk("lw_stall_cnt", n, 3);
    chk("lw_data", memwb_data, 32'hDEAD_BEEF);
    chk("lw_be", 32'(memwb_byte_en), 32'hF);

    // LW that never completes
    set_in(1, 1, 5'd8, 32'h0000_0200, 3'd5, 32'h0, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_out) break;
      n++;
      cyc();
    end
    cyc(); nop();
    chk("tmo_stall_cnt", n, TMO);
    chk("tmo_err", 32'(bus_err), 32'd1);
    chk("tmo_be", 32'(memwb_byte_en), 32'd0);
    cyc();
    chk("tmo_err_pulse", 32'(bus_err), 32'd0);

    // Misaligned LH, then LW to r0
    set_in(1, 1, 5'd6, 32'h0000_0301, 3'd3, 32'h1111_2222, 1'b0);
    #1;
    chk("lh_mis_nostall", 32'(stall_out), 32'd0);
    cyc(); nop();
    chk("lh_mis_be", 32'(memwb_byte_en), 32'd0);
    chk("lh_mis_err", 32'(bus_err), 32'd1);
    cyc();
    chk("lh_mis_pulse", 32'(bus_err), 32'd0);
    set_in(1, 1, 5'd0, 32'h0000_0400, 3'd5, 32'h0, 1'b0);
    #1;
    chk("r0_nostall", 32'(stall_out), 32'd0);
    cyc(); nop();
    chk("r0_be", 32'(memwb_byte_en), 32'd0);
    chk("r0_err", 32'(bus_err), 32'd0);

    // LWL / LWR
    set_in(1, 1, 5'd10, 32'h0000_0501, 3'd6, 32'hAABB_CCDD, 1'b1);
    cyc();
`ifdef MEM_WB_LWLR_EN
    chk("lwl_data", memwb_data, 32'hCCDD_0000);
    chk("lwl_be", 32'(memwb_byte_en), 32'hC);
`else
    chk("lwl_be", 32'(memwb_byte_en), 32'd0);
    chk("lwl_err", 32'(bus_err), 32'd1);
`endif
    lt = 3'd7;
    cyc(); nop();
`ifdef MEM_WB_LWLR_EN
    chk("lwr_data", memwb_data, 32'h00AA_BBCC);
    chk("lwr_be", 32'(memwb_byte_en), 32'h7);
`else
    chk("lwr_be", 32'(memwb_byte_en), 32'd0);
    chk("lwr_err", 32'(bus_err), 32'd1);
`endif
    cyc();

    // Flush during WAIT
    set_in(1, 1, 5'd11, 32'h0000_0600, 3'd5, 32'h0, 1'b0);
    cyc(); cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    nop();
    #1;
    chk("flush_stall", 32'(stall_out), 32'd0);
    chk("flush_be", 32'(memwb_byte_en), 32'd0);
    chk("flush_err", 32'(bus_err), 32'd0);
    cyc();

    // Reset in the middle of WAIT
    set_in(1, 1, 5'd12, 32'h0000_0700, 3'd5, 32'h0, 1'b0);
    cyc(); cyc();
    nop();
    rst_n = 1'b0;
    #1;
    chk("rstw_stall", 32'(stall_out), 32'd0);
    chk("rstw_be", 32'(memwb_byte_en), 32'd0);
    cyc();
    rst_n = 1'b1;
    set_in(1, 1, 5'd13, 32'hCAFE_F00D, 3'd0, 32'h0, 1'b0);
    cyc(); nop();
    chk("post_rst_data", memwb_data, 32'hCAFE_F00D);
    chk("post_rst_be", 32'(memwb_byte_en), 32'hF);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
